// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : FSM state encoding (IDLE / SHIFT / DONE)
//   DEFAULT_N : default operand/result width
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_N = 4;

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// One-bit full subtractor: computes x - y - br_in.
//   x      : minuend bit
//   y      : subtrahend bit
//   br_in  : borrow in
//   d      : difference bit
//   br_out : borrow out
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic br_in,
    output logic d,
    output logic br_out
);

    always_comb begin
        d      = x ^ y ^ br_in;
        br_out = (~x & y) | (~x & br_in) | (y & br_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   start : request an operation (sampled only while ready=1)
//   a, b  : minuend / subtrahend, captured on the accepting edge
//   b_in  : borrow in, captured on the accepting edge
//   ready : high in IDLE
//   done  : one-cycle pulse when diff/b_out/ovf become valid
//   diff  : result, held until the next accepted start
//   b_out : unsigned borrow out (a < b + b_in)
//   ovf   : signed two's-complement overflow
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned N  = DEFAULT_N,
    parameter int unsigned CW = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         b_out,
    output logic         ovf
);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic          br;
    logic          cell_d;
    logic          cell_bo;

    full_sub_cell u_cell (
        .x      (a_sr[0]),
        .y      (b_sr[0]),
        .br_in  (br),
        .d      (cell_d),
        .br_out (cell_bo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
            diff  <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= b_in;
                        cnt   <= '0;
                        diff  <= '0;
                        b_out <= 1'b0;
                        ovf   <= 1'b0;
                        ready <= 1'b0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Result bits enter at the MSB so bit 0 lands in diff[0] after N shifts.
                    diff <= {cell_d, diff[N-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= cell_bo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        // br still holds the borrow into the MSB on this edge.
                        b_out <= cell_bo;
                        ovf   <= br ^ cell_bo;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (N=4): directed vectors, random
// operations against an arithmetic reference model, back-to-back starts and
// mid-operation reset.
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic         ready;
    logic         done;
    logic [N-1:0] diff;
    logic         b_out;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int           done_at;
        int           done_cnt;
        int           ready_bad;
        logic [N-1:0] diff0;
        logic         bout0;
        logic         ovf0;
        logic [N-1:0] diff;
        logic         bout;
        logic         ovf;
        logic [N-1:0] diff_hold;
        logic         ready_end;
    } obs_t;

    serial_subtractor #(.N(N), .CW(3)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    always #5 clock = ~clock;

    // Reference: plain integer arithmetic, unsigned and signed views.
    function automatic void model(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                  input logic tbin, output logic [N-1:0] d,
                                  output logic bo, output logic ov);
        int r;
        int sa;
        int sb;
        int sr;
        r  = int'(ta) - int'(tb) - int'(tbin);
        sa = (int'(ta) >= 2 ** (N - 1)) ? int'(ta) - 2 ** N : int'(ta);
        sb = (int'(tb) >= 2 ** (N - 1)) ? int'(tb) - 2 ** N : int'(tb);
        sr = sa - sb - int'(tbin);
        d  = N'((r + 2 ** N) % (2 ** N));
        bo = (r < 0);
        ov = (sr < -(2 ** (N - 1))) || (sr > 2 ** (N - 1) - 1);
    endfunction

    // Called at a negedge with the DUT in IDLE. Drives one operation, perturbs
    // the inputs during SHIFT, and records what the DUT shows on each negedge
    // for N+2 cycles after the accepting edge (i = cycles since that edge).
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tbin, input logic hold, output obs_t o);
        start = 1'b1;
        a     = ta;
        b     = tb;
        b_in  = tbin;
        @(posedge clock);
        o.done_at   = -1;
        o.done_cnt  = 0;
        o.ready_bad = 0;
        for (int i = 0; i <= N + 1; i++) begin
            @(negedge clock);
            if (i == 0) begin
                if (!hold) start = 1'b0;
                o.diff0 = diff;
                o.bout0 = b_out;
                o.ovf0  = ovf;
            end
            if (i == 1) begin
                a    = ~ta;
                b    = ~tb;
                b_in = ~tbin;
            end
            if (done === 1'b1) begin
                o.done_cnt++;
                if (o.done_at < 0) o.done_at = i;
            end
            if (i <= N && ready !== 1'b0) o.ready_bad++;
            if (i == N) begin
                o.diff = diff;
                o.bout = b_out;
                o.ovf  = ovf;
            end
            if (i == N + 1) begin
                o.diff_hold = diff;
                o.ready_end = ready;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        a     = '1;
        b     = '0;
        b_in  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ready); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++;
        if (diff !== '0) begin n_fail++; $display("FAIL reset_diff got=%b want=0000", diff); end
        n_checks++;
        if (b_out !== 1'b0) begin n_fail++; $display("FAIL reset_bout got=%b want=0", b_out); end
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_directed();
        logic [N-1:0] va [6] = '{4'b0111, 4'b0011, 4'b1000, 4'b0000, 4'b0111, 4'b0110};
        logic [N-1:0] vb [6] = '{4'b0011, 4'b0111, 4'b0001, 4'b0000, 4'b1111, 4'b0001};
        logic         vc [6] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0};
        logic [N-1:0] wd [6] = '{4'b0100, 4'b1100, 4'b0111, 4'b1111, 4'b1000, 4'b0101};
        logic         wb [6] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0};
        logic         wo [6] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        obs_t o;
        for (int k = 0; k < 6; k++) begin
            do_op(va[k], vb[k], vc[k], 1'b0, o);
            n_checks++;
            if (o.done_at !== N || o.done_cnt !== 1) begin
                n_fail++;
                $display("FAIL dir%0d_done_timing got at=%0d cnt=%0d want at=%0d cnt=1", k, o.done_at, o.done_cnt, N);
            end
            n_checks++;
            if (o.ready_bad !== 0 || o.ready_end !== 1'b1) begin
                n_fail++;
                $display("FAIL dir%0d_ready got busy_hi=%0d end=%b want 0/1", k, o.ready_bad, o.ready_end);
            end
            n_checks++;
            if (o.diff !== wd[k] || o.bout !== wb[k] || o.ovf !== wo[k]) begin
                n_fail++;
                $display("FAIL dir%0d_result got diff=%b bout=%b ovf=%b want diff=%b bout=%b ovf=%b",
                         k, o.diff, o.bout, o.ovf, wd[k], wb[k], wo[k]);
            end
            n_checks++;
            if (o.diff0 !== '0 || o.bout0 !== 1'b0 || o.ovf0 !== 1'b0) begin
                n_fail++;
                $display("FAIL dir%0d_clear_on_accept got diff=%b bout=%b ovf=%b want 0000/0/0",
                         k, o.diff0, o.bout0, o.ovf0);
            end
            n_checks++;
            if (o.diff_hold !== wd[k]) begin
                n_fail++;
                $display("FAIL dir%0d_hold got=%b want=%b", k, o.diff_hold, wd[k]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        obs_t         o;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        logic [N-1:0] ed;
        logic         eb;
        logic         eo;
        for (int k = 0; k < 40; k++) begin
            ra = N'($urandom_range(2 ** N - 1));
            rb = N'($urandom_range(2 ** N - 1));
            rc = 1'($urandom_range(1));
            model(ra, rb, rc, ed, eb, eo);
            do_op(ra, rb, rc, 1'b0, o);
            n_checks++;
            if (o.done_at !== N || o.done_cnt !== 1 || o.diff !== ed || o.bout !== eb || o.ovf !== eo) begin
                n_fail++;
                $display("FAIL rnd%0d a=%b b=%b bin=%b got at=%0d cnt=%0d diff=%b bout=%b ovf=%b want at=%0d cnt=1 diff=%b bout=%b ovf=%b",
                         k, ra, rb, rc, o.done_at, o.done_cnt, o.diff, o.bout, o.ovf, N, ed, eb, eo);
            end
            if ($urandom_range(1) == 1) @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        obs_t         o;
        logic [N-1:0] ed;
        logic         eb;
        logic         eo;
        // First op: inputs flip to ~a/~b mid-SHIFT, start stays high.
        do_op(4'b0101, 4'b0010, 1'b0, 1'b1, o);
        n_checks++;
        if (o.diff !== 4'b0011 || o.bout !== 1'b0 || o.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first got diff=%b bout=%b ovf=%b want 0011/0/0", o.diff, o.bout, o.ovf);
        end
        n_checks++;
        if (o.done_cnt !== 1 || o.done_at !== N || o.ready_end !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_window got cnt=%0d at=%0d ready_end=%b want 1/%0d/1", o.done_cnt, o.done_at, o.ready_end, N);
        end
        // Second op must be accepted on the very next (first IDLE) edge.
        model(4'b1111, 4'b0110, 1'b1, ed, eb, eo);
        do_op(4'b1111, 4'b0110, 1'b1, 1'b1, o);
        n_checks++;
        if (o.done_at !== N || o.done_cnt !== 1 || o.ready_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_second_timing got at=%0d cnt=%0d busy_hi=%0d want %0d/1/0", o.done_at, o.done_cnt, o.ready_bad, N);
        end
        n_checks++;
        if (o.diff !== ed || o.bout !== eb || o.ovf !== eo) begin
            n_fail++;
            $display("FAIL b2b_second got diff=%b bout=%b ovf=%b want %b/%b/%b", o.diff, o.bout, o.ovf, ed, eb, eo);
        end
        start = 1'b0;
        repeat (N + 3) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   stray;
        start = 1'b1;
        a     = 4'b0110;
        b     = 4'b0001;
        b_in  = 1'b0;
        @(posedge clock);           // accept
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);           // first SHIFT edge
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);           // second SHIFT edge, reset applied
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || diff !== '0 || b_out !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state got ready=%b done=%b diff=%b bout=%b ovf=%b want 1/0/0000/0/0",
                     ready, done, diff, b_out, ovf);
        end
        stray = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || ready !== 1'b1) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet got bad_cycles=%0d want 0", stray);
        end
        do_op(4'b0110, 4'b0001, 1'b0, 1'b0, o);
        n_checks++;
        if (o.done_at !== N || o.diff !== 4'b0101 || o.bout !== 1'b0 || o.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_fresh got at=%0d diff=%b bout=%b ovf=%b want %0d/0101/0/0",
                     o.done_at, o.diff, o.bout, o.ovf, N);
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        b_in  = 1'b0;
        @(negedge clock);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
